// File: rtl/m68k_region_decoder.sv
// m68k_region_decoder
// Registered 68000 address-region decoder. Decodes the address captured at
// the start of a bus cycle into a one-hot chip select, counts per-region wait
// states (optionally gated by an external ready), and terminates the cycle
// with DTACK, or with BERR on unmapped or timed-out accesses.
module m68k_region_decoder #(
    parameter int                          N_REGIONS  = 4,
    parameter int                          ADDR_W     = 24,
    parameter logic [N_REGIONS*ADDR_W-1:0] BASES      = {24'h1c0000, 24'h180000, 24'h080000, 24'h000000},
    parameter logic [N_REGIONS*ADDR_W-1:0] LIMITS     = {24'h1c0003, 24'h180fff, 24'h083fff, 24'h07ffff},
    parameter logic [N_REGIONS*4-1:0]      WAITS      = {(N_REGIONS*4){1'b0}},
    parameter logic [N_REGIONS-1:0]        READY_MASK = 4'b0001,
    parameter int                          TIMEOUT    = 64
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            cpu_a,
    input  logic                         cpu_as_n,
    input  logic                         ext_ready,
    output logic [N_REGIONS-1:0]         cs,
    output logic [$clog2(N_REGIONS)-1:0] region,
    output logic                         hit,
    output logic                         cpu_dtack_n,
    output logic                         cpu_berr_n
);

    localparam int                   RW       = $clog2(N_REGIONS);
    localparam logic [7:0]           TMO_LOAD = 8'(TIMEOUT);
    localparam logic [N_REGIONS-1:0] CS_ONE   = {{(N_REGIONS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_TMO  = 3'd2,
        ST_ACK  = 3'd3,
        ST_BERR = 3'd4
    } state_t;

    state_t                 r_state,   w_state_nxt;
    logic                   r_as_prev;
    logic                   r_ready;
    logic [7:0]             r_cnt,     w_cnt_nxt;
    logic [7:0]             r_tcnt,    w_tcnt_nxt;
    logic                   r_gated,   w_gated_nxt;
    logic [N_REGIONS-1:0]   r_cs,      w_cs_nxt;
    logic [RW-1:0]          r_region,  w_region_nxt;
    logic                   r_hit,     w_hit_nxt;
    logic                   r_dtack_n, w_dtack_n_nxt;
    logic                   r_berr_n,  w_berr_n_nxt;

    logic [ADDR_W-1:0]      w_addr;
    logic                   w_match;
    logic [RW-1:0]          w_match_idx;
    logic [3:0]             w_match_wait;
    logic                   w_match_gated;
    logic                   w_start;

    // A cycle starts on the first low sample of AS after a high sample.
    assign w_start = r_as_prev & ~cpu_as_n;

    // Range decode; scanning from the top index down lets the lowest match win.
    always_comb begin
        w_addr        = {cpu_a[ADDR_W-1:1], 1'b0};
        w_match       = 1'b0;
        w_match_idx   = {RW{1'b0}};
        w_match_wait  = 4'd0;
        w_match_gated = 1'b0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((w_addr >= BASES[i*ADDR_W +: ADDR_W]) && (w_addr <= LIMITS[i*ADDR_W +: ADDR_W])) begin
                w_match       = 1'b1;
                w_match_idx   = RW'(i);
                w_match_wait  = WAITS[i*4 +: 4];
                w_match_gated = READY_MASK[i];
            end else begin
                w_match       = w_match;
                w_match_idx   = w_match_idx;
                w_match_wait  = w_match_wait;
                w_match_gated = w_match_gated;
            end
        end
    end

    // Next-state and next-output logic of the bus-cycle FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tcnt_nxt    = r_tcnt;
        w_gated_nxt   = r_gated;
        w_cs_nxt      = r_cs;
        w_region_nxt  = r_region;
        w_hit_nxt     = r_hit;
        w_dtack_n_nxt = r_dtack_n;
        w_berr_n_nxt  = r_berr_n;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_match) begin
                        w_state_nxt  = ST_WAIT;
                        w_region_nxt = w_match_idx;
                        w_cs_nxt     = CS_ONE << w_match_idx;
                        w_hit_nxt    = 1'b1;
                        w_cnt_nxt    = {4'd0, w_match_wait};
                        w_tcnt_nxt   = TMO_LOAD;
                        w_gated_nxt  = w_match_gated;
                    end else begin
                        w_state_nxt  = ST_TMO;
                        w_cs_nxt     = {N_REGIONS{1'b0}};
                        w_hit_nxt    = 1'b0;
                        w_cnt_nxt    = TMO_LOAD;
                        w_tcnt_nxt   = 8'd0;
                        w_gated_nxt  = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cpu_as_n) begin
                    // Abort: the CPU withdrew the cycle before termination.
                    w_state_nxt = ST_IDLE;
                    w_cs_nxt    = {N_REGIONS{1'b0}};
                    w_hit_nxt   = 1'b0;
                    w_cnt_nxt   = 8'd0;
                    w_tcnt_nxt  = 8'd0;
                end else if (r_cnt == 8'd0) begin
                    if (!r_gated || r_ready) begin
                        w_state_nxt   = ST_ACK;
                        w_dtack_n_nxt = 1'b0;
                    end else if (r_tcnt <= 8'd1) begin
                        w_state_nxt  = ST_BERR;
                        w_berr_n_nxt = 1'b0;
                        w_tcnt_nxt   = 8'd0;
                    end else begin
                        w_tcnt_nxt = r_tcnt - 8'd1;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt - 8'd1;
                    w_tcnt_nxt = (r_tcnt == 8'd0) ? 8'd0 : (r_tcnt - 8'd1);
                end
            end
            ST_TMO: begin
                if (cpu_as_n) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_tcnt_nxt  = 8'd0;
                end else if (r_cnt <= 8'd1) begin
                    w_state_nxt  = ST_BERR;
                    w_berr_n_nxt = 1'b0;
                    w_cnt_nxt    = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_ACK, ST_BERR: begin
                if (cpu_as_n) begin
                    w_state_nxt   = ST_IDLE;
                    w_cs_nxt      = {N_REGIONS{1'b0}};
                    w_hit_nxt     = 1'b0;
                    w_dtack_n_nxt = 1'b1;
                    w_berr_n_nxt  = 1'b1;
                    w_cnt_nxt     = 8'd0;
                    w_tcnt_nxt    = 8'd0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cs_nxt      = {N_REGIONS{1'b0}};
                w_hit_nxt     = 1'b0;
                w_dtack_n_nxt = 1'b1;
                w_berr_n_nxt  = 1'b1;
                w_cnt_nxt     = 8'd0;
                w_tcnt_nxt    = 8'd0;
            end
        endcase
    end

    // State, counters, input samples and registered outputs. AS history resets
    // low so a cycle already in progress at reset release is not restarted.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_as_prev <= 1'b0;
            r_ready   <= 1'b0;
            r_cnt     <= 8'd0;
            r_tcnt    <= 8'd0;
            r_gated   <= 1'b0;
            r_cs      <= {N_REGIONS{1'b0}};
            r_region  <= {RW{1'b0}};
            r_hit     <= 1'b0;
            r_dtack_n <= 1'b1;
            r_berr_n  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_as_prev <= cpu_as_n;
            r_ready   <= ext_ready;
            r_cnt     <= w_cnt_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_gated   <= w_gated_nxt;
            r_cs      <= w_cs_nxt;
            r_region  <= w_region_nxt;
            r_hit     <= w_hit_nxt;
            r_dtack_n <= w_dtack_n_nxt;
            r_berr_n  <= w_berr_n_nxt;
        end
    end

    assign cs          = r_cs;
    assign region      = r_region;
    assign hit         = r_hit;
    assign cpu_dtack_n = r_dtack_n;
    assign cpu_berr_n  = r_berr_n;

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Testbench for m68k_region_decoder: directed scenarios plus randomized bus
// cycles, each compared edge by edge against a timing model derived from the
// decoder's address-map and termination rules.
module tb_m68k_region_decoder;

    localparam int          TMO    = 64;
    localparam int          NEVER  = 100000;
    localparam logic [95:0] P_BASES  = {24'h1c0000, 24'h180000, 24'h080000, 24'h000000};
    localparam logic [95:0] P_LIMITS = {24'h1c0003, 24'h180fff, 24'h083fff, 24'h080001};
    localparam logic [15:0] P_WAITS  = {4'd5, 4'd3, 4'd0, 4'd0};
    localparam logic [3:0]  P_RMASK  = 4'b0001;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [23:0] cpu_a;
    logic        cpu_as_n;
    logic        ext_ready;
    logic [3:0]  cs;
    logic [1:0]  region;
    logic        hit;
    logic        cpu_dtack_n;
    logic        cpu_berr_n;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] obs_cs     [0:127];
    logic [1:0] obs_region [0:127];
    logic       obs_hit    [0:127];
    logic       obs_dtack  [0:127];
    logic       obs_berr   [0:127];

    m68k_region_decoder #(
        .N_REGIONS  (4),
        .ADDR_W     (24),
        .BASES      (P_BASES),
        .LIMITS     (P_LIMITS),
        .WAITS      (P_WAITS),
        .READY_MASK (P_RMASK),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .cpu_a       (cpu_a),
        .cpu_as_n    (cpu_as_n),
        .ext_ready   (ext_ready),
        .cs          (cs),
        .region      (region),
        .hit         (hit),
        .cpu_dtack_n (cpu_dtack_n),
        .cpu_berr_n  (cpu_berr_n)
    );

    always #5 clk_sys = ~clk_sys;

    // Address map lookup: lowest-numbered inclusive range containing the even address.
    function automatic void model_decode(input logic [23:0] a, output bit mapped, output int idx);
        logic [23:0] ae;
        ae = {a[23:1], 1'b0};
        mapped = 1'b0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (!mapped && ae >= P_BASES[i*24 +: 24] && ae <= P_LIMITS[i*24 +: 24]) begin
                mapped = 1'b1;
                idx = i;
            end
        end
    endfunction

    // Edge offset from E0 after which DTACK is low (NEVER if it never is).
    function automatic int model_ack(input bit mapped, input int idx, input int rise);
        int w;
        int k;
        if (!mapped) return NEVER;
        w = int'(P_WAITS[idx*4 +: 4]);
        if (!P_RMASK[idx]) return w + 1;
        if (rise < 0) return NEVER;
        k = (rise + 1 > w + 1) ? rise + 1 : w + 1;
        if (k > TMO) return NEVER;
        return k;
    endfunction

    // Edge offset from E0 after which BERR is low (NEVER if it never is).
    function automatic int model_berr(input bit mapped, input int ack);
        if (!mapped) return TMO;
        if (ack == NEVER) return TMO;
        return NEVER;
    endfunction

    // One bus cycle: optional idle edges, AS low at addr, ext_ready rising at
    // edge E0+rise (never if negative), AS sampled high at edge E0+rel.
    task automatic run_cycle(input logic [23:0] addr, input int rise, input int rel,
                             input int idle_edges, input bit scramble);
        bit         mapped;
        int         idx;
        int         ack_e;
        int         berr_e;
        bit         act;
        logic [3:0] e_cs;
        logic       e_hit;
        logic       e_dt;
        logic       e_be;
        cpu_as_n  = 1'b1;
        ext_ready = 1'b0;
        for (int k = 0; k < idle_edges; k++) begin
            @(posedge clk_sys);
            #1;
            n_vec++;
            if ({cs, hit, cpu_dtack_n, cpu_berr_n} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL idle: got cs=%b hit=%b dtack_n=%b berr_n=%b, expected 0000 0 1 1",
                         cs, hit, cpu_dtack_n, cpu_berr_n);
            end
        end
        model_decode(addr, mapped, idx);
        ack_e  = model_ack(mapped, idx, rise);
        berr_e = model_berr(mapped, ack_e);
        cpu_a     = addr;
        cpu_as_n  = 1'b0;
        ext_ready = (rise == 0);
        for (int n = 0; n <= rel; n++) begin
            @(posedge clk_sys);
            #1;
            act   = (n < rel);
            e_hit = act && mapped;
            e_cs  = e_hit ? (4'b0001 << idx) : 4'b0000;
            e_dt  = !(act && n >= ack_e);
            e_be  = !(act && n >= berr_e);
            if (n < 128) begin
                obs_cs[n]     = cs;
                obs_region[n] = region;
                obs_hit[n]    = hit;
                obs_dtack[n]  = cpu_dtack_n;
                obs_berr[n]   = cpu_berr_n;
            end
            n_vec++;
            if ({cs, hit, cpu_dtack_n, cpu_berr_n} !== {e_cs, e_hit, e_dt, e_be}) begin
                n_err++;
                $display("FAIL cycle addr=%h E0+%0d: got cs=%b hit=%b dtack_n=%b berr_n=%b, expected cs=%b hit=%b dtack_n=%b berr_n=%b",
                         addr, n, cs, hit, cpu_dtack_n, cpu_berr_n, e_cs, e_hit, e_dt, e_be);
            end
            if (e_hit) begin
                n_vec++;
                if (region !== idx[1:0]) begin
                    n_err++;
                    $display("FAIL region addr=%h E0+%0d: got %0d, expected %0d", addr, n, region, idx);
                end
            end
            cpu_as_n  = (n + 1 >= rel);
            ext_ready = (rise >= 0 && n + 1 >= rise);
            if (scramble) cpu_a = 24'($urandom);
        end
        cpu_as_n  = 1'b1;
        ext_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        cpu_as_n  = 1'b1;
        cpu_a     = 24'h000000;
        ext_ready = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        n_vec++;
        if ({cs, region, hit, cpu_dtack_n, cpu_berr_n} !== {4'b0000, 2'd0, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values: got cs=%b region=%0d hit=%b dtack_n=%b berr_n=%b", cs, region, hit, cpu_dtack_n, cpu_berr_n);
        end
        // AS already low when reset releases: must not be taken as a cycle start.
        cpu_a    = 24'h080010;
        cpu_as_n = 1'b0;
        #2 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_sys);
            #1;
            n_vec++;
            if ({hit, cpu_dtack_n, cpu_berr_n} !== {1'b0, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL reset_no_restart: got hit=%b dtack_n=%b berr_n=%b, expected 0 1 1", hit, cpu_dtack_n, cpu_berr_n);
            end
        end
        cpu_as_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        run_cycle(24'h080010, -1, 3, 2, 1'b0);
        n_vec++;
        if (obs_cs[0] !== 4'b0010 || obs_region[0] !== 2'd1) begin
            n_err++;
            $display("FAIL zero_wait_select: got cs=%b region=%0d, expected 0010 1", obs_cs[0], obs_region[0]);
        end
        n_vec++;
        if (obs_dtack[0] !== 1'b1 || obs_dtack[1] !== 1'b0) begin
            n_err++;
            $display("FAIL zero_wait_dtack: got %b%b, expected 10", obs_dtack[0], obs_dtack[1]);
        end
        n_vec++;
        if (obs_cs[3] !== 4'b0000 || obs_hit[3] !== 1'b0 || obs_dtack[3] !== 1'b1) begin
            n_err++;
            $display("FAIL zero_wait_release: got cs=%b hit=%b dtack_n=%b", obs_cs[3], obs_hit[3], obs_dtack[3]);
        end
    endtask

    task automatic test_wait_states();
        run_cycle(24'h180800, -1, 7, 1, 1'b1);
        n_vec++;
        if (obs_dtack[3] !== 1'b1 || obs_dtack[4] !== 1'b0) begin
            n_err++;
            $display("FAIL wait_states_dtack: got E0+3=%b E0+4=%b, expected 1 0", obs_dtack[3], obs_dtack[4]);
        end
        for (int n = 0; n < 7; n++) begin
            n_vec++;
            if (obs_cs[n] !== 4'b0100) begin
                n_err++;
                $display("FAIL wait_states_cs E0+%0d: got %b, expected 0100", n, obs_cs[n]);
            end
        end
    endtask

    task automatic test_ready_gating();
        run_cycle(24'h000100, 5, 9, 1, 1'b0);
        n_vec++;
        if (obs_dtack[5] !== 1'b1 || obs_dtack[6] !== 1'b0) begin
            n_err++;
            $display("FAIL ready_dtack: got E0+5=%b E0+6=%b, expected 1 0", obs_dtack[5], obs_dtack[6]);
        end
        run_cycle(24'h000100, -1, 66, 1, 1'b0);
        n_vec++;
        if (obs_berr[63] !== 1'b1 || obs_berr[64] !== 1'b0) begin
            n_err++;
            $display("FAIL ready_timeout_berr: got E0+63=%b E0+64=%b, expected 1 0", obs_berr[63], obs_berr[64]);
        end
        for (int n = 0; n <= 66; n++) begin
            n_vec++;
            if (obs_dtack[n] !== 1'b1) begin
                n_err++;
                $display("FAIL ready_timeout_dtack E0+%0d: got %b, expected 1", n, obs_dtack[n]);
            end
        end
    endtask

    task automatic test_unmapped();
        run_cycle(24'h200000, -1, 66, 1, 1'b1);
        for (int n = 0; n <= 66; n++) begin
            n_vec++;
            if (obs_cs[n] !== 4'b0000 || obs_hit[n] !== 1'b0) begin
                n_err++;
                $display("FAIL unmapped_select E0+%0d: got cs=%b hit=%b, expected 0000 0", n, obs_cs[n], obs_hit[n]);
            end
        end
        n_vec++;
        if (obs_berr[63] !== 1'b1 || obs_berr[64] !== 1'b0 || obs_berr[66] !== 1'b1) begin
            n_err++;
            $display("FAIL unmapped_berr: got E0+63=%b E0+64=%b E0+66=%b, expected 1 0 1", obs_berr[63], obs_berr[64], obs_berr[66]);
        end
    endtask

    task automatic test_overlap_boundaries();
        logic [23:0] addrs [0:6];
        logic [4:0]  want  [0:6];   // {hit, cs}
        addrs[0] = 24'h080000; want[0] = 5'b1_0001;
        addrs[1] = 24'h080001; want[1] = 5'b1_0001;
        addrs[2] = 24'h083fff; want[2] = 5'b1_0010;
        addrs[3] = 24'h084000; want[3] = 5'b0_0000;
        addrs[4] = 24'h1c0003; want[4] = 5'b1_1000;
        addrs[5] = 24'h1c0004; want[5] = 5'b0_0000;
        addrs[6] = 24'h07fffe; want[6] = 5'b1_0001;
        for (int t = 0; t < 7; t++) begin
            run_cycle(addrs[t], 0, 8, 1, 1'b0);
            n_vec++;
            if ({obs_hit[0], obs_cs[0]} !== want[t]) begin
                n_err++;
                $display("FAIL boundary addr=%h: got hit=%b cs=%b, expected %b", addrs[t], obs_hit[0], obs_cs[0], want[t]);
            end
        end
    endtask

    task automatic test_abort();
        run_cycle(24'h1c0002, -1, 2, 1, 1'b0);
        for (int n = 0; n <= 2; n++) begin
            n_vec++;
            if (obs_dtack[n] !== 1'b1 || obs_berr[n] !== 1'b1) begin
                n_err++;
                $display("FAIL abort_wait E0+%0d: got dtack_n=%b berr_n=%b, expected 1 1", n, obs_dtack[n], obs_berr[n]);
            end
        end
        n_vec++;
        if (obs_cs[2] !== 4'b0000 || obs_hit[2] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_clear: got cs=%b hit=%b, expected 0000 0", obs_cs[2], obs_hit[2]);
        end
        run_cycle(24'h080020, -1, 3, 0, 1'b0);
        n_vec++;
        if (obs_cs[0] !== 4'b0010 || obs_dtack[1] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_fresh: got cs=%b dtack_n=%b, expected 0010 0", obs_cs[0], obs_dtack[1]);
        end
        run_cycle(24'h300000, -1, 10, 1, 1'b0);
        n_vec++;
        if (obs_berr[9] !== 1'b1 || obs_berr[10] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_tmo: got berr_n=%b%b, expected 11", obs_berr[9], obs_berr[10]);
        end
    endtask

    task automatic test_reset_during_ack();
        cpu_as_n  = 1'b1;
        ext_ready = 1'b0;
        @(posedge clk_sys);
        #1;
        cpu_a    = 24'h080040;
        cpu_as_n = 1'b0;
        @(posedge clk_sys);
        #1;
        @(posedge clk_sys);
        #1;
        n_vec++;
        if (cpu_dtack_n !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ack_before: got dtack_n=%b, expected 0", cpu_dtack_n);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({cs, hit, cpu_dtack_n, cpu_berr_n} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL rst_ack_immediate: got cs=%b hit=%b dtack_n=%b berr_n=%b", cs, hit, cpu_dtack_n, cpu_berr_n);
        end
        #2 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_sys);
            #1;
            n_vec++;
            if ({cs, hit, cpu_dtack_n, cpu_berr_n} !== {4'b0000, 1'b0, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL rst_ack_no_restart: got cs=%b hit=%b dtack_n=%b berr_n=%b", cs, hit, cpu_dtack_n, cpu_berr_n);
            end
        end
        run_cycle(24'h080040, -1, 3, 1, 1'b0);
        n_vec++;
        if (obs_dtack[1] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ack_retoggle: got dtack_n=%b, expected 0", obs_dtack[1]);
        end
    endtask

    task automatic test_back_to_back();
        int          mode;
        logic [23:0] addr;
        int          rise;
        bit          mapped;
        int          idx;
        int          ack_e;
        int          berr_e;
        int          done;
        int          rel;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 4);
            case (mode)
                0:       addr = 24'($urandom_range(0, 32'h080001));
                1:       addr = 24'(32'h080000 + $urandom_range(0, 32'h3fff));
                2:       addr = 24'(32'h180000 + $urandom_range(0, 32'h0fff));
                3:       addr = 24'(32'h1c0000 + $urandom_range(0, 3));
                default: addr = 24'($urandom);
            endcase
            rise = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
            model_decode(addr, mapped, idx);
            ack_e  = model_ack(mapped, idx, rise);
            berr_e = model_berr(mapped, ack_e);
            done   = (ack_e < berr_e) ? ack_e : berr_e;
            if ($urandom_range(0, 4) == 0) rel = $urandom_range(1, done);
            else rel = done + int'($urandom_range(1, 3));
            run_cycle(addr, rise, rel, $urandom_range(0, 2), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_ready_gating();
        test_unmapped();
        test_overlap_boundaries();
        test_abort();
        test_reset_during_ack();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule

// File: doc/m68k_region_decoder.md
# m68k_region_decoder

Parametrised, registered 68000 address-region decoder with per-region wait states and bus-cycle termination. It maps the CPU address to a one-hot chip-select over `N_REGIONS` programmable inclusive ranges, generates `cpu_dtack_n` after a per-region wait count and optionally after an external ready, and raises `cpu_berr_n` on unmapped or timed-out cycles. It sits between the 68000 core and the board's memory/IO blocks, replacing hand-written fixed-latency select logic.

## Interface
- `N_REGIONS`, default 4: number of decoded regions.
- `ADDR_W`, default 24: CPU address width.
- `BASES`, default {24'h1c0000, 24'h180000, 24'h080000, 24'h000000}: packed `N_REGIONS*ADDR_W`; region i start is bits [i*ADDR_W +: ADDR_W].
- `LIMITS`, default {24'h1c0003, 24'h180fff, 24'h083fff, 24'h07ffff}: packed inclusive end addresses, same packing.
- `WAITS`, default all 4'd0: packed `N_REGIONS*4`, wait cycles per region (0–15).
- `READY_MASK`, default 4'b0001: bit i set means region i also waits for `ext_ready`.
- `TIMEOUT`, default 64: cycles before bus error (1–255).

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_a` in ADDR_W: byte address. Bit 0 is ignored and compared as 0.
- `cpu_as_n` in 1: address strobe, active low.
- `ext_ready` in 1: slow-memory ready, level, sampled on `clk_sys`.
- `cs` out N_REGIONS: registered one-hot chip select.
- `region` out $clog2(N_REGIONS): index of the active region, valid while `hit`.
- `hit` out 1: a mapped cycle is in progress.
- `cpu_dtack_n` out 1: data acknowledge, active low.
- `cpu_berr_n` out 1: bus error, active low.

## Operation
- Match rule: region i matches when BASES[i] ≤ {cpu_a[ADDR_W-1:1],1'b0} ≤ LIMITS[i]. Comparisons are unsigned, ADDR_W bits wide.
- Overlaps: the lowest matching index wins. `cs` is never multi-hot.
- Cycle start: `cpu_as_n` sampled low when the previously sampled value was high. Call this edge E0.
- FSM states and transitions:
  - IDLE → WAIT on cycle start with a match. At E0: latch `region`, set `cs` bit and `hit`, load the counter with WAITS[i].
  - IDLE → TMO on cycle start with no match. At E0: load the counter with TIMEOUT, keep `cs`=0 and `hit`=0.
  - WAIT: decrement the counter each cycle.
    - Counter = 0 and (READY_MASK[i]=0 or `ext_ready`=1) → ACK.
    - Counter = 0 and ready-gated region with `ext_ready`=0 → a separate timeout counter, started at E0, reaching TIMEOUT → BERR.
  - TMO: decrement the counter. Reaching 0 → BERR.
  - ACK: `cpu_dtack_n`=0. Stay until `cpu_as_n` sampled high → IDLE.
  - BERR: `cpu_berr_n`=0. Stay until `cpu_as_n` sampled high → IDLE.
- Abort: `cpu_as_n` sampled high in WAIT or TMO → IDLE at that edge. No DTACK or BERR is emitted, and `cs`, `hit`, and the counters clear.
- Leaving ACK or BERR: `cs`, `hit`, `cpu_dtack_n` and `cpu_berr_n` return to idle values on the edge that samples `cpu_as_n` high.
- `cpu_dtack_n` and `cpu_berr_n` are never low at the same time.
- The address is captured only at E0. Changes to `cpu_a` while AS is low are ignored.

## Timing
- All outputs are registered on the `clk_sys` rising edge.
- Reset values (asynchronous, while `reset_n`=0):
  - `cs`=0, `region`=0, `hit`=0.
  - `cpu_dtack_n`=1, `cpu_berr_n`=1.
  - FSM = IDLE, counters = 0.
  - Reset asserted mid-cycle forces these values immediately. After release, a cycle already holding AS low is not restarted until AS is seen high, then low again.
- Mapped region, W waits, not ready-gated: `cs` is high after E0, `cpu_dtack_n` low after edge E0+W+1.
- Ready-gated region: DTACK falls after edge max(E0+W+1, E_r+1), where E_r is the first edge at which `ext_ready`=1 with the counter at 0.
- Unmapped address: `cpu_berr_n` low after edge E0+TIMEOUT.
- Ready-gated timeout: `cpu_berr_n` low after edge E0+TIMEOUT, but only if ACK has not been reached earlier.
- Back-to-back cycles: AS must be sampled high for at least one edge between cycles. The new E0 is the next low sample.

## Test plan
- **Zero-wait RAM:** reset, AS low at 24'h080010 → `cs`=4'b0010 and `region`=1 after E0; DTACK low after E0+1; AS high → all outputs idle on the next edge.
- **Wait states:** WAITS[2]=3, AS low at 24'h180800 → DTACK low after E0+4, `cs`=4'b0100 throughout.
- **Ready gating:** region 0 at 24'h000100, `ext_ready` rises at E0+5 → DTACK low after E0+6. Repeat with `ext_ready` held low → BERR low after E0+64, DTACK stays high.
- **Unmapped address:** AS low at 24'h200000 → `cs`=0 and `hit`=0 throughout; BERR low after E0+64; released on AS high.
- **Overlap and boundaries:**
  - Set LIMITS[0]=24'h080001 so it overlaps region 1 → 24'h080000 selects region 0.
  - 24'h083fff selects region 1.
  - 24'h084000 is unmapped.
  - 24'h1c0003 selects region 3.
- **Abort and reset:**
  - AS deasserted at E0+2 with WAITS=5 → no DTACK; the next cycle decodes fresh.
  - `reset_n` pulsed low during ACK → DTACK high immediately, no new cycle until AS toggles.
